sha256_compress: RTL and testbench

- Downstream consumer of the SHA-256 message scheduler.
- Takes one 2048-bit expanded schedule (64 × 32-bit words W0..W63) per 512-bit block.
- Runs the 64 compression rounds iteratively, one round per clock, then adds the result into the chaining state.
- Chains multiple blocks of one message and presents the 256-bit digest with a one-cycle valid pulse.

---
 rtl/sha256_pkg.sv | 56 +++++
 rtl/sha256_round.sv | 40 ++++
 rtl/sha256_compress.sv | 142 ++++++++++++++
 tb/tb_sha256_compress.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, state encoding and round helper functions
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] SHA256_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA224_IV [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word i of the initial hash value; sel224 picks the truncated-variant IV.
    function automatic logic [31:0] iv_word(input logic [2:0] i, input logic sel224);
        return sel224 ? SHA224_IV[i] : SHA256_IV[i];
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] f,
    input  logic [31:0] g,
    input  logic [31:0] h,
    input  logic [31:0] kt,
    input  logic [31:0] wt,
    output logic [31:0] a_next,
    output logic [31:0] b_next,
    output logic [31:0] c_next,
    output logic [31:0] d_next,
    output logic [31:0] e_next,
    output logic [31:0] f_next,
    output logic [31:0] g_next,
    output logic [31:0] h_next
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + kt + wt;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign a_next = t1 + t2;
    assign b_next = a;
    assign c_next = b;
    assign d_next = c;
    assign e_next = d + t1;
    assign f_next = e;
    assign g_next = f;
    assign h_next = g;

endmodule

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - iterative SHA-256 compression with chaining; SHA256_SHA224_MODE_EN adds SHA-224 IV select
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2047:0] words,
    input  logic          first_block,
`ifdef SHA256_SHA224_MODE_EN
    input  logic          sha224,
`endif
    input  logic          valid_in,
    output logic          ready_out,
    output logic [255:0]  digest,
    output logic          digest_valid
);

    localparam int CW = $clog2(ROUNDS);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [2047:0]     w_reg;
    logic [7:0][31:0]  work;
    logic [7:0][31:0]  rnd;
    logic [7:0][31:0]  h_reg;
    logic [7:0][31:0]  h_new;
    logic [7:0][31:0]  iv_in;
    logic [255:0]      digest_d;
    logic              first_q;
    logic              sel224_in;
    logic              sel224_q;
    logic              accept;
    logic              last_round;
    logic [31:0]       wt;

`ifdef SHA256_SHA224_MODE_EN
    assign sel224_in = sha224;
`else
    assign sel224_in = 1'b0;
`endif

    assign ready_out  = (state == IDLE);
    assign accept     = valid_in && ready_out;
    assign last_round = (cnt == CW'(ROUNDS - 1));
    assign wt         = w_reg[{cnt, 5'b00000} +: 32];

    sha256_round u_round (
        .a      (work[0]),
        .b      (work[1]),
        .c      (work[2]),
        .d      (work[3]),
        .e      (work[4]),
        .f      (work[5]),
        .g      (work[6]),
        .h      (work[7]),
        .kt     (K[cnt]),
        .wt     (wt),
        .a_next (rnd[0]),
        .b_next (rnd[1]),
        .c_next (rnd[2]),
        .d_next (rnd[3]),
        .e_next (rnd[4]),
        .f_next (rnd[5]),
        .g_next (rnd[6]),
        .h_next (rnd[7])
    );

    // State register; reset always lands in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one accept, 64 rounds, one feed-forward cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ROUND;
            ROUND:   if (last_round) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // IV for a new block, feed-forward sum and big-endian digest packing (H0 on top).
    always_comb begin
        iv_in    = '0;
        h_new    = '0;
        digest_d = '0;
        for (int i = 0; i < 8; i++) begin
            iv_in[i] = iv_word(3'(i), sel224_in);
            h_new[i] = (first_q ? iv_word(3'(i), sel224_q) : h_reg[i]) + work[i];
            digest_d[32*(7-i) +: 32] = h_new[i];
        end
    end

    // Datapath: capture on accept, iterate rounds, fold into chaining state on FINAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            first_q      <= 1'b0;
            sel224_q     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= SHA256_IV[i];
            end
        end else begin
            digest_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        w_reg    <= words;
                        first_q  <= first_block;
                        sel224_q <= sel224_in;
                        cnt      <= '0;
                        for (int i = 0; i < 8; i++) begin
                            work[i] <= first_block ? iv_in[i] : h_reg[i];
                        end
                    end
                end
                ROUND: begin
                    work <= rnd;
                    cnt  <= cnt + CW'(1);
                end
                FINAL: begin
                    h_reg        <= h_new;
                    digest       <= digest_d;
                    digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - self-checking bench for sha256_compress
module tb_sha256_compress;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    localparam logic [255:0] ABC_HASH = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_HASH = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_HASH = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] MSG_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] MSG_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] MSG_TWO1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] MSG_TWO2 = {{15{32'h0}}, 32'h000001c0};

    typedef struct {
        logic [511:0] msg;
        bit           first;
        logic [255:0] exp;
        bit           chk;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2047:0] words;
    logic          first_block;
    logic          valid_in;
`ifdef SHA256_SHA224_MODE_EN
    logic          sha224_in;
`endif
    logic          ready_out;
    logic [255:0]  digest;
    logic          digest_valid;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [255:0] mdl_h;
    logic [255:0] got;
    vec_t         tbl [4];

    sha256_compress dut (
        .clk          (clk),
        .rst          (rst),
        .words        (words),
        .first_block  (first_block),
`ifdef SHA256_SHA224_MODE_EN
        .sha224       (sha224_in),
`endif
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message expansion from 16 big-endian words to the 64-word schedule, W0 in the LSBs.
    function automatic logic [2047:0] expand(input logic [511:0] m);
        logic [31:0]   w [64];
        logic [2047:0] out;
        for (int j = 0; j < 16; j++) w[j] = m[511-32*j -: 32];
        for (int j = 16; j < 64; j++)
            w[j] = w[j-16] + (rr(w[j-15], 7) ^ rr(w[j-15], 18) ^ (w[j-15] >> 3))
                 + w[j-7] + (rr(w[j-2], 17) ^ rr(w[j-2], 19) ^ (w[j-2] >> 10));
        for (int j = 0; j < 64; j++) out[32*j +: 32] = w[j];
        return out;
    endfunction

    // Full FIPS 180-4 block compression including the feed-forward add.
    function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [2047:0] w);
        logic [31:0]  v [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [255:0] out;
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
               + KT[t] + w[32*t +: 32];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) out[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return out;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one block, follow it to its digest pulse and compare with the model.
    task automatic run_block(input logic [511:0] msg, input bit first, input bit s224, input bit noise);
        logic [2047:0] w;
        logic [255:0]  base;
        int            n;
        bit            rdy_bad;
        w = expand(msg);
        check("ready before accept", 256'(ready_out), 256'd1);
        words       = w;
        first_block = first;
        valid_in    = 1'b1;
`ifdef SHA256_SHA224_MODE_EN
        sha224_in   = s224;
`endif
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        base  = first ? (s224 ? IV224 : IV256) : mdl_h;
        mdl_h = model_compress(base, w);
        n = 0;
        rdy_bad = 1'b0;
        while (n < 100) begin
            if (noise) begin
                valid_in    = 1'($urandom);
                first_block = 1'($urandom);
                for (int j = 0; j < 64; j++) words[32*j +: 32] = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
            if (digest_valid) break;
            if (ready_out) rdy_bad = 1'b1;
        end
        valid_in = 1'b0;
        check("accept-to-digest_valid edges", 256'(n), 256'd65);
        check("ready_out low while busy", 256'(rdy_bad), 256'd0);
        check("ready_out after final", 256'(ready_out), 256'd1);
        check("digest vs model", digest, mdl_h);
        got = digest;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] rm;
        bit           dv_seen;
        rst         = 1'b1;
        valid_in    = 1'b0;
        first_block = 1'b0;
        words       = '0;
`ifdef SHA256_SHA224_MODE_EN
        sha224_in   = 1'b0;
`endif
        mdl_h = IV256;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset ready_out", 256'(ready_out), 256'd1);
        check("reset digest_valid", 256'(digest_valid), 256'd0);
        check("reset digest", digest, 256'd0);

        tbl[0] = '{MSG_ABC,   1'b1, ABC_HASH,   1'b1};
        tbl[1] = '{MSG_EMPTY, 1'b1, EMPTY_HASH, 1'b1};
        tbl[2] = '{MSG_TWO1,  1'b1, '0,         1'b0};
        tbl[3] = '{MSG_TWO2,  1'b0, TWO_HASH,   1'b1};
        for (int i = 0; i < 4; i++) begin
            run_block(tbl[i].msg, tbl[i].first, 1'b0, 1'b0);
            if (tbl[i].chk) check($sformatf("vector %0d digest", i), got, tbl[i].exp);
        end

        @(posedge clk);
        #1;
        check("digest_valid single cycle", 256'(digest_valid), 256'd0);
        check("digest holds", digest, TWO_HASH);

        run_block(MSG_ABC, 1'b1, 1'b0, 1'b1);
        check("abc with valid_in noise", got, ABC_HASH);

        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 16; j++) rm[32*j +: 32] = $urandom;
            run_block(rm, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        for (int j = 0; j < 16; j++) rm[32*j +: 32] = $urandom;
        words       = expand(rm);
        first_block = 1'b1;
        valid_in    = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_h = IV256;
        check("abort ready_out", 256'(ready_out), 256'd1);
        check("abort digest cleared", digest, 256'd0);
        dv_seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (digest_valid) dv_seen = 1'b1;
        end
        check("no digest_valid after abort", 256'(dv_seen), 256'd0);
        run_block(MSG_ABC, 1'b0, 1'b0, 1'b0);
        check("abc chained from reset IV", got, ABC_HASH);

        rst         = 1'b1;
        valid_in    = 1'b1;
        words       = expand(MSG_ABC);
        first_block = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        mdl_h    = IV256;
        check("rst beats valid_in", 256'(ready_out), 256'd1);

`ifdef SHA256_SHA224_MODE_EN
        run_block(MSG_ABC, 1'b1, 1'b1, 1'b0);
        check("sha224 abc", {got[255:32], 32'h0},
              {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
